// File: rtl/score_session_ctrl_if.sv
// Session-controller bus: event inputs from the collision path, score and
// scan outputs toward the seven-segment decoders.
interface score_session_ctrl_if;
   logic       start;
   logic       good_evt;
   logic       bad_evt;
   logic [7:0] score;
   logic [7:0] high_score;
   logic [1:0] state;
   logic       game_over;
   logic [1:0] digit_sel;
   logic [3:0] digit_val;
   logic       digit_en;

   modport master (
      output start, good_evt, bad_evt,
      input  score, high_score, state, game_over, digit_sel, digit_val, digit_en
   );

   modport slave (
      input  start, good_evt, bad_evt,
      output score, high_score, state, game_over, digit_sel, digit_val, digit_en
   );
endinterface

// File: rtl/score_session_ctrl.sv
// Game-session controller: IDLE/RUN/OVER sequencing, event arbitration,
// binary+BCD score/high-score tracking and 3-digit multiplexed display scan.
module score_session_ctrl #(
   parameter int MAX_SCORE   = 140,
   parameter int BLINK_HALF  = 25,
   parameter int OVER_CYCLES = 300
) (
   input logic                 clk,
   input logic                 rst,
   score_session_ctrl_if.slave bus
);

   localparam int OW = $clog2(OVER_CYCLES + 1);
   localparam int BW = $clog2(BLINK_HALF + 1);
   localparam logic [OW-1:0] OVER_LAST  = OW'(OVER_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
   localparam logic [7:0]    SCORE_MAX  = 8'(MAX_SCORE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_OVER = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    score_q, score_d;
   logic [7:0]    high_q, high_d;
   logic [11:0]   score_bcd_q, score_bcd_d;
   logic [11:0]   high_bcd_q, high_bcd_d;
   logic          game_over_q, game_over_d;
   logic [OW-1:0] over_cnt_q, over_cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_on_q, blink_on_d;
   logic [1:0]    digit_sel_q, digit_sel_d;
   logic [3:0]    digit_val_q, digit_val_d;
   logic          digit_en_q, digit_en_d;

   logic [11:0]   disp_bcd;
   logic          blank;

   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v[3:0] == 4'd9) begin
         r[3:0] = 4'd0;
         if (v[7:4] == 4'd9) begin
            r[7:4]  = 4'd0;
            r[11:8] = v[11:8] + 4'd1;
         end else begin
            r[7:4] = v[7:4] + 4'd1;
         end
      end else begin
         r[3:0] = v[3:0] + 4'd1;
      end
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      score_d     = score_q;
      high_d      = high_q;
      score_bcd_d = score_bcd_q;
      high_bcd_d  = high_bcd_q;
      game_over_d = 1'b0;
      over_cnt_d  = over_cnt_q;
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d     = S_RUN;
               score_d     = '0;
               score_bcd_d = '0;
            end
         end
         S_RUN: begin
            // bad_evt and the auto-end both preempt any good_evt this cycle
            if (bus.bad_evt || score_q == SCORE_MAX) begin
               state_d     = S_OVER;
               game_over_d = 1'b1;
               over_cnt_d  = '0;
               blink_cnt_d = '0;
               blink_on_d  = 1'b1;
            end else if (bus.good_evt) begin
               score_d     = score_q + 8'd1;
               score_bcd_d = bcd_inc(score_bcd_q);
               if (score_d > high_q) begin
                  high_d     = score_d;
                  high_bcd_d = score_bcd_d;
               end
            end
         end
         S_OVER: begin
            if (bus.start) begin
               state_d     = S_RUN;
               score_d     = '0;
               score_bcd_d = '0;
               over_cnt_d  = '0;
               blink_cnt_d = '0;
               blink_on_d  = 1'b1;
            end else if (over_cnt_q == OVER_LAST) begin
               state_d     = S_IDLE;
               over_cnt_d  = '0;
               blink_cnt_d = '0;
               blink_on_d  = 1'b1;
            end else begin
               over_cnt_d = over_cnt_q + 1'b1;
               if (blink_cnt_q == BLINK_LAST) begin
                  blink_cnt_d = '0;
                  blink_on_d  = ~blink_on_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Scan registers are fed from next-state values so the displayed digit
      // tracks the state change and digit_sel on the same edge.
      digit_sel_d = (digit_sel_q == 2'd2) ? 2'd0 : digit_sel_q + 2'd1;
      disp_bcd    = (state_d == S_IDLE) ? high_bcd_d : score_bcd_d;
      case (digit_sel_d)
         2'd0: begin
            digit_val_d = disp_bcd[3:0];
            blank       = 1'b0;
         end
         2'd1: begin
            digit_val_d = disp_bcd[7:4];
            blank       = (disp_bcd[11:8] == 4'd0) && (disp_bcd[7:4] == 4'd0);
         end
         default: begin
            digit_val_d = disp_bcd[11:8];
            blank       = (disp_bcd[11:8] == 4'd0);
         end
      endcase
      digit_en_d = ~blank && ((state_d != S_OVER) || blink_on_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         score_q     <= '0;
         high_q      <= '0;
         score_bcd_q <= '0;
         high_bcd_q  <= '0;
         game_over_q <= 1'b0;
         over_cnt_q  <= '0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         digit_sel_q <= '0;
         digit_val_q <= '0;
         digit_en_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         score_q     <= score_d;
         high_q      <= high_d;
         score_bcd_q <= score_bcd_d;
         high_bcd_q  <= high_bcd_d;
         game_over_q <= game_over_d;
         over_cnt_q  <= over_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         digit_sel_q <= digit_sel_d;
         digit_val_q <= digit_val_d;
         digit_en_q  <= digit_en_d;
      end
   end

   assign bus.score      = score_q;
   assign bus.high_score = high_q;
   assign bus.state      = state_q;
   assign bus.game_over  = game_over_q;
   assign bus.digit_sel  = digit_sel_q;
   assign bus.digit_val  = digit_val_q;
   assign bus.digit_en   = digit_en_q;

endmodule

// File: tb/tb_score_session_ctrl.sv
// Bench for score_session_ctrl: directed session scenarios plus random events,
// every cycle compared against an arithmetic session model.
module tb_score_session_ctrl;
   localparam int MAX_SCORE   = 140;
   localparam int BLINK_HALF  = 25;
   localparam int OVER_CYCLES = 300;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   score_session_ctrl_if bus ();

   score_session_ctrl #(
      .MAX_SCORE  (MAX_SCORE),
      .BLINK_HALF (BLINK_HALF),
      .OVER_CYCLES(OVER_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // model: 0=IDLE 1=RUN 2=OVER; m_k = cycles already spent in OVER
   int m_state, m_score, m_high, m_k, m_go, m_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_score = 0; m_high = 0; m_k = 0; m_go = 0; m_cyc = 0;
   endtask

   task automatic model_step(input bit s, input bit g, input bit b);
      m_go = 0;
      case (m_state)
         0: if (s) begin m_state = 1; m_score = 0; end
         1: begin
            if (b || m_score == MAX_SCORE) begin
               m_state = 2; m_go = 1; m_k = 0;
            end else if (g) begin
               m_score++;
               if (m_score > m_high) m_high = m_score;
            end
         end
         default: begin
            if (s) begin m_state = 1; m_score = 0; end
            else if (m_k == OVER_CYCLES - 1) m_state = 0;
            else m_k++;
         end
      endcase
      m_cyc++;
   endtask

   task automatic check_all();
      int sel, disp, dig, en;
      bit blanked;
      sel  = m_cyc % 3;
      disp = (m_state == 0) ? m_high : m_score;
      case (sel)
         0: begin dig = disp % 10;        blanked = 0; end
         1: begin dig = (disp / 10) % 10; blanked = (disp < 10); end
         default: begin dig = disp / 100; blanked = (disp < 100); end
      endcase
      en = (!blanked && (m_state != 2 || ((m_k / BLINK_HALF) % 2 == 0))) ? 1 : 0;
      check("score",      32'(bus.score),      32'(m_score));
      check("high_score", 32'(bus.high_score), 32'(m_high));
      check("state",      32'(bus.state),      32'(m_state));
      check("game_over",  32'(bus.game_over),  32'(m_go));
      check("digit_sel",  32'(bus.digit_sel),  32'(sel));
      check("digit_val",  32'(bus.digit_val),  32'(dig));
      check("digit_en",   32'(bus.digit_en),   32'(en));
   endtask

   task automatic step(input bit s, input bit g, input bit b);
      bus.start = s; bus.good_evt = g; bus.bad_evt = b;
      @(posedge clk);
      model_step(s, g, b);
      #1;
      bus.start = 1'b0; bus.good_evt = 1'b0; bus.bad_evt = 1'b0;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   task automatic goods(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0);
   endtask

   task automatic async_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #2;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.good_evt = 1'b0; bus.bad_evt = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // 12 points: ones=2, tens=1, hundreds blanked
      step(1, 0, 0);
      goods(12);
      idle(6);
      step(0, 0, 1);
      idle(5);

      // restart from OVER, reach 9, then simultaneous good+bad
      step(1, 0, 0);
      goods(9);
      step(0, 1, 1);
      idle(4);

      // 99 -> 100 carry, then run into auto-end with good held high
      step(1, 0, 0);
      goods(99);
      idle(3);
      step(0, 1, 0);
      idle(3);
      goods(45);
      idle(OVER_CYCLES + 6);

      // high score persists across a lower session; IDLE shows it
      async_reset();
      step(1, 0, 0);
      goods(20);
      step(0, 0, 1);
      idle(OVER_CYCLES + 3);
      step(1, 0, 0);
      goods(5);
      step(0, 0, 1);
      idle(OVER_CYCLES + 3);

      // reset in the middle of a run
      step(1, 0, 0);
      goods(7);
      async_reset();
      idle(4);

      // random event traffic
      for (int i = 0; i < 4000; i++) begin
         step(($urandom % 60) == 0, ($urandom % 3) != 0, ($urandom % 180) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
